// File: rtl/dram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_ctrl_pkg
// Description : Shared types and constants for the DRAM command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_ctrl_pkg;

    localparam int ROW_W  = 11;
    localparam int COL_W  = 10;
    localparam int ADDR_W = ROW_W + COL_W;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PRE      = 4'd1,
        ST_WAIT_RP  = 4'd2,
        ST_ACT      = 4'd3,
        ST_WAIT_RCD = 4'd4,
        ST_RD       = 4'd5,
        ST_WAIT_Q   = 4'd6,
        ST_WR       = 4'd7,
        ST_WAIT_WR  = 4'd8,
        ST_RESP     = 4'd9
    } state_t;

    typedef struct packed {
        logic       csn;
        logic       rasn;
        logic       casn;
        logic [3:0] wen;
    } cmd_t;

    // Deselected pins, the state held while in reset.
    localparam cmd_t CMD_DES = '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
    localparam cmd_t CMD_NOP = '{csn: 1'b0, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
    localparam cmd_t CMD_ACT = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'hF};
    localparam cmd_t CMD_PRE = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'h0};
    localparam cmd_t CMD_RD  = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};
    localparam cmd_t CMD_WR  = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'h0};

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_ctrl_if
// Description : Request/response channel between the client and dram_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_ctrl_if;
    import dram_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wstrb, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wstrb, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dram_ctrl
// Description : Open-row DRAM command sequencer with tRP/tRCD/tWR spacing
//               and a read-data timeout; all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int T_RP  = 5,
    parameter int T_RCD = 5,
    parameter int T_WR  = 2,
    parameter int T_TO  = 64
) (
    input  wire              clk,
    input  wire              rst,
    dram_ctrl_if.slave       bus,
    output logic             DRAM_CSn,
    output logic             DRAM_RASn,
    output logic             DRAM_CASn,
    output logic [3:0]       DRAM_WEn,
    output logic [ROW_W-1:0] DRAM_A,
    output logic [31:0]      DRAM_D,
    input  wire  [31:0]      DRAM_Q,
    input  wire              DRAM_valid
);

    localparam int c_WAIT_MAX = max2(max2(T_RP, T_RCD), max2(T_WR, T_TO));
    localparam int c_CNT_W    = (c_WAIT_MAX < 1) ? 1 : $clog2(c_WAIT_MAX + 1);

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    cmd_t                r_cmd, w_cmd_nxt;
    logic [ROW_W-1:0]    r_a, w_a_nxt;
    logic [31:0]         r_d, w_d_nxt;
    logic                r_rsp_valid, w_rsp_nxt;
    logic [31:0]         r_rsp_rdata, w_rdata_nxt;
    logic                r_rsp_err, w_err_nxt;
    logic                r_req_ready;

    logic                r_write;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic [3:0]          r_wstrb;
    logic [31:0]         r_wdata;
    logic                r_row_open;
    logic [ROW_W-1:0]    r_open_row;

    logic                w_accept;
    logic                w_sel_write;
    logic [ROW_W-1:0]    w_sel_row;
    logic [COL_W-1:0]    w_sel_col;
    logic [3:0]          w_sel_wstrb;
    logic [31:0]         w_sel_wdata;
    logic                w_row_hit;
    logic                w_go_pre, w_go_act, w_go_col, w_go_resp;
    logic [31:0]         w_resp_data;
    logic                w_resp_err;

    assign w_accept = bus.req_valid & r_req_ready;

    // On the accept cycle the request is not latched yet, so decode straight from the bus.
    assign w_sel_write = w_accept ? bus.req_write                     : r_write;
    assign w_sel_row   = w_accept ? bus.req_addr[ADDR_W-1:COL_W]      : r_row;
    assign w_sel_col   = w_accept ? bus.req_addr[COL_W-1:0]           : r_col;
    assign w_sel_wstrb = w_accept ? bus.req_wstrb                     : r_wstrb;
    assign w_sel_wdata = w_accept ? bus.req_wdata                     : r_wdata;
    assign w_row_hit   = r_row_open && (r_open_row == w_sel_row);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cmd_nxt   = CMD_NOP;
        w_a_nxt     = r_a;
        w_d_nxt     = r_d;
        w_rsp_nxt   = 1'b0;
        w_rdata_nxt = r_rsp_rdata;
        w_err_nxt   = r_rsp_err;
        w_go_pre    = 1'b0;
        w_go_act    = 1'b0;
        w_go_col    = 1'b0;
        w_go_resp   = 1'b0;
        w_resp_data = '0;
        w_resp_err  = 1'b0;

        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    if (w_row_hit)       w_go_col = 1'b1;
                    else if (r_row_open) w_go_pre = 1'b1;
                    else                 w_go_act = 1'b1;
                end
            end
            ST_PRE: begin
                if (T_RP == 0) w_go_act = 1'b1;
                else begin
                    w_state_nxt = ST_WAIT_RP;
                    w_cnt_nxt   = c_CNT_W'(T_RP - 1);
                end
            end
            ST_WAIT_RP: begin
                if (r_cnt == '0) w_go_act = 1'b1;
                else             w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
            ST_ACT: begin
                if (T_RCD == 0) w_go_col = 1'b1;
                else begin
                    w_state_nxt = ST_WAIT_RCD;
                    w_cnt_nxt   = c_CNT_W'(T_RCD - 1);
                end
            end
            ST_WAIT_RCD: begin
                if (r_cnt == '0) w_go_col = 1'b1;
                else             w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
            ST_WR: begin
                if (T_WR == 0) w_go_resp = 1'b1;
                else begin
                    w_state_nxt = ST_WAIT_WR;
                    w_cnt_nxt   = c_CNT_W'(T_WR - 1);
                end
            end
            ST_WAIT_WR: begin
                if (r_cnt == '0) w_go_resp = 1'b1;
                else             w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
            ST_RD: begin
                if (T_TO == 0) begin
                    w_go_resp  = 1'b1;
                    w_resp_err = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT_Q;
                    w_cnt_nxt   = c_CNT_W'(T_TO - 1);
                end
            end
            ST_WAIT_Q: begin
                // Data arriving on the final counted cycle still wins over the timeout.
                if (DRAM_valid) begin
                    w_go_resp   = 1'b1;
                    w_resp_data = DRAM_Q;
                end else if (r_cnt == '0) begin
                    w_go_resp  = 1'b1;
                    w_resp_err = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_go_pre) begin
            w_state_nxt = ST_PRE;
            w_cmd_nxt   = CMD_PRE;
        end
        if (w_go_act) begin
            w_state_nxt = ST_ACT;
            w_cmd_nxt   = CMD_ACT;
            w_a_nxt     = w_sel_row;
        end
        if (w_go_col) begin
            w_a_nxt = {{(ROW_W-COL_W){1'b0}}, w_sel_col};
            if (w_sel_write) begin
                w_state_nxt   = ST_WR;
                w_cmd_nxt     = CMD_WR;
                w_cmd_nxt.wen = ~w_sel_wstrb;
                w_d_nxt       = w_sel_wdata;
            end else begin
                w_state_nxt = ST_RD;
                w_cmd_nxt   = CMD_RD;
            end
        end
        if (w_go_resp) begin
            w_state_nxt = ST_RESP;
            w_rsp_nxt   = 1'b1;
            w_rdata_nxt = w_resp_data;
            w_err_nxt   = w_resp_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd       <= CMD_DES;
            r_a         <= '0;
            r_d         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_write     <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_row_open  <= 1'b0;
            r_open_row  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_a         <= w_a_nxt;
            r_d         <= w_d_nxt;
            r_rsp_valid <= w_rsp_nxt;
            r_rsp_rdata <= w_rdata_nxt;
            r_rsp_err   <= w_err_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_write <= bus.req_write;
                r_row   <= bus.req_addr[ADDR_W-1:COL_W];
                r_col   <= bus.req_addr[COL_W-1:0];
                r_wstrb <= bus.req_wstrb;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == ST_ACT) begin
                r_row_open <= 1'b1;
                r_open_row <= r_row;
            end
        end
    end

    assign DRAM_CSn      = r_cmd.csn;
    assign DRAM_RASn     = r_cmd.rasn;
    assign DRAM_CASn     = r_cmd.casn;
    assign DRAM_WEn      = r_cmd.wen;
    assign DRAM_A        = r_a;
    assign DRAM_D        = r_d;
    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_ctrl
// Description : Self-checking bench for dram_ctrl: timeline reference model,
//               directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_ctrl;

    localparam int T_RP  = 5;
    localparam int T_RCD = 5;
    localparam int T_WR  = 2;
    localparam int T_TO  = 64;
    localparam int SPAN  = 128;

    // Pin patterns {CSn, RASn, CASn, WEn[3:0]}
    localparam logic [6:0] P_DES = 7'b111_1111;
    localparam logic [6:0] P_NOP = 7'b011_1111;
    localparam logic [6:0] P_ACT = 7'b001_1111;
    localparam logic [6:0] P_PRE = 7'b001_0000;
    localparam logic [6:0] P_RD  = 7'b010_1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic [31:0] DRAM_Q;
    logic        DRAM_valid;

    always #5 clk = ~clk;

    dram_ctrl_if bus ();

    dram_ctrl #(
        .T_RP (T_RP),
        .T_RCD(T_RCD),
        .T_WR (T_WR),
        .T_TO (T_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .DRAM_CSn  (DRAM_CSn),
        .DRAM_RASn (DRAM_RASn),
        .DRAM_CASn (DRAM_CASn),
        .DRAM_WEn  (DRAM_WEn),
        .DRAM_A    (DRAM_A),
        .DRAM_D    (DRAM_D),
        .DRAM_Q    (DRAM_Q),
        .DRAM_valid(DRAM_valid)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected timeline, keyed by cycle number
    bit          busy     [int];
    bit          rv       [int];
    logic [6:0]  e_pin    [int];
    logic [10:0] e_a      [int];
    logic [31:0] e_d      [int];
    bit          e_rsp    [int];
    bit          e_rsp_rd [int];
    logic [31:0] e_rdata  [int];
    bit          e_err    [int];

    bit          m_row_open = 1'b0;
    logic [10:0] m_open_row = '0;
    int          rd_r   = -1000;
    int          rd_end = -1000;
    bit          rd_hit = 1'b0;
    logic [31:0] rd_q   = '0;

    // Observations for the literal checks
    int          o_act = -1, o_pre = -1, o_col = -1, o_rsp = -1;
    logic [10:0] o_act_a = '0, o_col_a = '0;
    logic [31:0] o_rdata = '0;
    logic        o_err = 1'b0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endfunction

    function automatic void set_cmd(input int c, input logic [6:0] p, input bit has_a,
                                    input logic [10:0] a, input bit has_d, input logic [31:0] d);
        e_pin[c] = p;
        if (has_a) e_a[c] = a;
        if (has_d) e_d[c] = d;
    endfunction

    function automatic void model_accept(input int n, input bit w, input logic [20:0] addr,
                                         input logic [3:0] s, input logic [31:0] wd,
                                         input int d, input logic [31:0] q);
        int colc, rspc;
        logic [10:0] row;
        logic [9:0]  col;
        row = addr[20:10];
        col = addr[9:0];
        if (m_row_open && m_open_row == row) begin
            colc = n + 1;
        end else if (m_row_open) begin
            set_cmd(n + 1, P_PRE, 1'b0, '0, 1'b0, '0);
            set_cmd(n + 2 + T_RP, P_ACT, 1'b1, row, 1'b0, '0);
            colc = n + 3 + T_RP + T_RCD;
        end else begin
            set_cmd(n + 1, P_ACT, 1'b1, row, 1'b0, '0);
            colc = n + 2 + T_RCD;
        end
        m_row_open = 1'b1;
        m_open_row = row;
        if (w) begin
            set_cmd(colc, {3'b010, ~s}, 1'b1, {1'b0, col}, 1'b1, wd);
            rspc = colc + 1 + T_WR;
            e_rsp_rd[rspc] = 1'b0;
            e_err[rspc]    = 1'b0;
        end else begin
            set_cmd(colc, P_RD, 1'b1, {1'b0, col}, 1'b0, '0);
            rd_r = colc;
            rd_q = q;
            if (d == 0) begin
                rd_end = colc + T_TO;
                rd_hit = 1'b0;
                rspc   = colc + T_TO + 1;
                e_rdata[rspc] = '0;
                e_err[rspc]   = 1'b1;
            end else begin
                rd_end = colc + d;
                rd_hit = 1'b1;
                rspc   = colc + d + 1;
                e_rdata[rspc] = q;
                e_err[rspc]   = 1'b0;
            end
            e_rsp_rd[rspc] = 1'b1;
        end
        e_rsp[rspc] = 1'b1;
        for (int c = n + 1; c < rspc; c++) busy[c] = 1'b1;
    endfunction

    function automatic void model_reset(input int c);
        for (int k = c + 1; k <= c + SPAN; k++) begin
            busy.delete(k);
            e_pin.delete(k);
            e_a.delete(k);
            e_d.delete(k);
            e_rsp.delete(k);
            e_rsp_rd.delete(k);
            e_rdata.delete(k);
            e_err.delete(k);
        end
        rv[c + 1]  = 1'b1;
        m_row_open = 1'b0;
        rd_r       = -1000;
        rd_end     = -1000;
    endfunction

    // DRAM side: valid only where the read schedule puts it, random noise elsewhere
    task automatic drive_dram(input int c);
        if (c > rd_r && c <= rd_end) begin
            DRAM_valid = (c == rd_end) && rd_hit;
            DRAM_Q     = DRAM_valid ? rd_q : $urandom;
        end else begin
            DRAM_valid = ($urandom_range(0, 3) == 0);
            DRAM_Q     = $urandom;
        end
    endtask

    task automatic step(input bit r, input bit v, input bit w, input logic [20:0] a,
                        input logic [3:0] s, input logic [31:0] wd, input int d, input logic [31:0] q);
        rst           = r;
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wstrb = s;
        bus.req_wdata = wd;
        if (r)                          model_reset(cyc);
        else if (v && !busy.exists(cyc)) model_accept(cyc, w, a, s, wd, d, q);
        drive_dram(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'($urandom), 21'($urandom), 4'($urandom), $urandom, 0, '0);
    endtask

    always @(negedge clk) begin : compare
        logic [6:0] pins;
        pins = {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn};
        if (cyc >= 1) begin
            if (rv.exists(cyc)) begin
                chk("rst_pins",  32'(pins), 32'(P_DES));
                chk("rst_a",     32'(DRAM_A), 32'd0);
                chk("rst_d",     DRAM_D, 32'd0);
                chk("rst_rspv",  32'(bus.rsp_valid), 32'd0);
                chk("rst_rdata", bus.rsp_rdata, 32'd0);
                chk("rst_err",   32'(bus.rsp_err), 32'd0);
                chk("rst_ready", 32'(bus.req_ready), 32'd1);
            end else begin
                chk("req_ready", 32'(bus.req_ready), 32'(!busy.exists(cyc)));
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp.exists(cyc)));
                if (e_rsp.exists(cyc)) begin
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e_err[cyc]));
                    if (e_rsp_rd[cyc]) chk("rsp_rdata", bus.rsp_rdata, e_rdata[cyc]);
                end
                if (e_pin.exists(cyc)) begin
                    chk("cmd_pins", 32'(pins), 32'(e_pin[cyc]));
                    if (e_a.exists(cyc)) chk("cmd_a", 32'(DRAM_A), 32'(e_a[cyc]));
                    if (e_d.exists(cyc)) chk("cmd_d", DRAM_D, e_d[cyc]);
                end else begin
                    chk("nop_pins", 32'(pins), 32'(P_NOP));
                end
            end
            if (pins == P_ACT) begin o_act = cyc; o_act_a = DRAM_A; end
            if (pins == P_PRE) o_pre = cyc;
            if (!DRAM_CSn && DRAM_RASn && !DRAM_CASn) begin o_col = cyc; o_col_a = DRAM_A; end
            if (bus.rsp_valid) begin o_rsp = cyc; o_rdata = bus.rsp_rdata; o_err = bus.rsp_err; end
        end
    end

    initial begin : stim
        int n;
        bit r, v;
        int d, sel;
        logic [10:0] row;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0, '0, 0, '0);
        idle(2);

        // Cold write
        n = cyc;
        step(1'b0, 1'b1, 1'b1, 21'h00405, 4'hF, 32'hDEADBEEF, 0, '0);
        idle(14);
        chk("cold_act_at",  32'(o_act - n), 32'd1);
        chk("cold_act_a",   32'(o_act_a), 32'h001);
        chk("cold_wr_at",   32'(o_col - n), 32'd7);
        chk("cold_wr_a",    32'(o_col_a), 32'h005);
        chk("cold_rsp_at",  32'(o_rsp - n), 32'd10);

        // Hit read, data 3 cycles after RD
        n = cyc;
        step(1'b0, 1'b1, 1'b0, 21'h00406, 4'h0, '0, 3, 32'h12345678);
        idle(10);
        chk("hit_no_act",   32'(o_act < n), 32'd1);
        chk("hit_rd_at",    32'(o_col - n), 32'd1);
        chk("hit_rsp_at",   32'(o_rsp - n), 32'd5);
        chk("hit_rdata",    o_rdata, 32'h12345678);
        chk("hit_err",      32'(o_err), 32'd0);

        // Row miss
        n = cyc;
        step(1'b0, 1'b1, 1'b0, 21'h00C00, 4'h0, '0, 2, 32'hA5A55A5A);
        idle(25);
        chk("miss_pre_at",  32'(o_pre - n), 32'd1);
        chk("miss_act_at",  32'(o_act - n), 32'd7);
        chk("miss_act_a",   32'(o_act_a), 32'h003);
        chk("miss_col_at",  32'(o_col - n), 32'd13);
        chk("miss_rsp_at",  32'(o_rsp - n), 32'd16);

        // Read timeout
        n = cyc;
        step(1'b0, 1'b1, 1'b0, 21'h00C01, 4'h0, '0, 0, '0);
        idle(T_TO + 10);
        chk("to_rsp_after_rd", 32'(o_rsp - o_col), 32'(T_TO + 1));
        chk("to_err",       32'(o_err), 32'd1);
        chk("to_rdata",     o_rdata, 32'd0);

        // Reset during WAIT_RCD of a row-miss write
        n = cyc;
        step(1'b0, 1'b1, 1'b1, 21'h01400, 4'h3, 32'hCAFEF00D, 0, '0);
        idle(8);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 0, '0);
        idle(2);
        n = cyc;
        step(1'b0, 1'b1, 1'b1, 21'h01401, 4'h0, 32'h0BADC0DE, 0, '0);
        idle(14);
        chk("mrst_act_at",  32'(o_act - n), 32'd1);
        chk("mrst_no_pre",  32'(o_pre < n), 32'd1);
        chk("mrst_rsp_at",  32'(o_rsp - n), 32'd10);

        // Randomized traffic over a few rows
        for (int i = 0; i < 2500; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            v   = !r && ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 9);
            d   = (sel == 0) ? 0 : (sel == 1) ? T_TO : $urandom_range(1, 6);
            row = 11'($urandom_range(0, 3) * 2 + 1);
            step(r, v, 1'($urandom), {row, 10'($urandom)},
                 ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                 $urandom, d, $urandom);
        end
        idle(T_TO + 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
